reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_pkg.sv | 29 ++
 rtl/arb_write_queue.sv | 102 ++++++++++
 rtl/mux2.sv | 20 ++
 rtl/reg_write_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter_pkg
// Shared types and constants for the register-file write-port arbiter.
//   REG_IDX_W / DATA_W : register index and data widths
//   LINK_INDEX/PC_INDEX: architecturally special register indices
//   arb_state_t        : arbiter state encoding
//   q_entry_t          : one deferred-write queue entry {live, sel, val}
// -----------------------------------------------------------------------------
package reg_write_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  localparam logic [REG_IDX_W-1:0] LINK_INDEX = 5'd30;
  localparam logic [REG_IDX_W-1:0] PC_INDEX   = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // queue empty
    ST_DRAIN = 2'd1,  // queue non-empty, head not yet starved
    ST_FORCE = 2'd2   // head starved: steal the port from the pipeline
  } arb_state_t;

  typedef struct packed {
    logic                 live;
    logic [REG_IDX_W-1:0] sel;
    logic [DATA_W-1:0]    val;
  } q_entry_t;

endpackage

// File: rtl/arb_write_queue.sv
// -----------------------------------------------------------------------------
// arb_write_queue
// Deferred-write FIFO for multi-cycle results. Entry 0 is always the head;
// a pop shifts the array down by one. A squash clears the live bit of every
// stored entry (and of the entry being pushed) whose index matches.
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   i_push             : store {i_push_sel, i_push_val} (caller ensures not full)
//   i_pop              : drop the head (caller ensures not empty)
//   i_squash           : clear live on entries whose sel equals i_squash_sel
//   o_count            : number of occupied entries
//   o_head_live/sel/val: head entry fields
//   o_any_live         : at least one stored entry is live
// -----------------------------------------------------------------------------
module arb_write_queue
  import reg_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_push,
  input  logic [REG_IDX_W-1:0] i_push_sel,
  input  logic [DATA_W-1:0]    i_push_val,
  input  logic                 i_pop,
  input  logic                 i_squash,
  input  logic [REG_IDX_W-1:0] i_squash_sel,
  output logic [CW-1:0]        o_count,
  output logic                 o_head_live,
  output logic [REG_IDX_W-1:0] o_head_sel,
  output logic [DATA_W-1:0]    o_head_val,
  output logic                 o_any_live
);

  q_entry_t      r_q [DEPTH];
  logic [CW-1:0] r_count;

  q_entry_t      w_sq  [DEPTH];
  q_entry_t      w_nxt [DEPTH];
  logic [CW-1:0] w_wr_idx;
  logic          w_push_live;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_sq[i] = r_q[i];
      if (i_squash && (r_q[i].sel == i_squash_sel)) begin
        w_sq[i].live = 1'b0;
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i] = w_sq[i];
    end

    // Slots at or above r_count are kept all-zero so o_any_live can OR
    // every slot without masking by the count.
    if (i_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        w_nxt[i] = w_sq[i + 1];
      end
      w_nxt[DEPTH-1] = '0;
    end

    // The push lands after the shift, so its slot is count minus the pop.
    w_wr_idx    = r_count - CW'(i_pop);
    w_push_live = !(i_squash && (i_push_sel == i_squash_sel));
    if (i_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == w_wr_idx) begin
          w_nxt[i] = {w_push_live, i_push_sel, i_push_val};
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= w_nxt[i];
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_comb begin
    o_any_live = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      o_any_live = o_any_live | r_q[i].live;
    end
  end

  assign o_count     = r_count;
  assign o_head_live = r_q[0].live;
  assign o_head_sel  = r_q[0].sel;
  assign o_head_val  = r_q[0].val;

endmodule

// File: rtl/mux2.sv
// -----------------------------------------------------------------------------
// mux2
// Generic two-input multiplexer cell.
//   i_sel : 0 selects i_d0, 1 selects i_d1
//   i_d0  : input 0
//   i_d1  : input 1
//   o_y   : selected output
// -----------------------------------------------------------------------------
module mux2 #(
  parameter int W = 1
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
// Shares the single register-file write port between the pipeline write-back
// stage and a multi-cycle unit. Multi-cycle results are parked in a small
// FIFO and written when the pipeline leaves the port free. A head that has
// been denied STARVE_LIMIT cycles in a row forces a pipeline stall and takes
// the port. A pipeline write to register X kills any queued write to X, so a
// stale queued value can never overwrite a newer pipeline result.
//
// Ports
//   clock_i, reset_i            : clock, asynchronous active-high reset
//   wb_enable_i/select_i/value_i: pipeline write-back request
//   mc_valid_i/select_i/value_i : multi-cycle result offer
//   mc_ready_o                  : queue accepts an mc result this cycle
//   stall_o                     : pipeline must hold its write-back this cycle
//   write_reg_o                 : register file write data
//   select_write_reg_o          : register file write index
//   reg_write_enable_o          : register file write strobe
//   busy_o                      : queue holds at least one live entry
//
// Handshake: an mc result transfers on a rising clock edge where both
// mc_valid_i and mc_ready_o are high. mc_ready_o depends only on the
// registered occupancy, never on a pop happening in the same cycle.
// -----------------------------------------------------------------------------
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int QUEUE_DEPTH  = 2
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 wb_enable_i,
  input  logic [REG_IDX_W-1:0] wb_select_i,
  input  logic [DATA_W-1:0]    wb_value_i,
  input  logic                 mc_valid_i,
  input  logic [REG_IDX_W-1:0] mc_select_i,
  input  logic [DATA_W-1:0]    mc_value_i,
  output logic                 mc_ready_o,
  output logic                 stall_o,
  output logic [DATA_W-1:0]    write_reg_o,
  output logic [REG_IDX_W-1:0] select_write_reg_o,
  output logic                 reg_write_enable_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int AW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] Q_FULL  = CW'(QUEUE_DEPTH);
  localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_LIMIT);

  arb_state_t    r_state;
  logic [AW-1:0] r_age;

  arb_state_t           w_next_state;
  logic [AW-1:0]        w_next_age;
  logic [CW-1:0]        w_next_count;
  logic [CW-1:0]        w_q_count;
  logic                 w_head_live;
  logic [REG_IDX_W-1:0] w_head_sel;
  logic [DATA_W-1:0]    w_head_val;
  logic                 w_any_live;
  logic                 w_nonempty;
  logic                 w_force;
  logic                 w_mc_ready;
  logic                 w_accept;
  logic                 w_grant_wb;
  logic                 w_grant_q;
  logic                 w_pop;
  logic                 w_stall;
  logic                 w_port_en;
  logic [DATA_W-1:0]    w_src_val;
  logic [REG_IDX_W-1:0] w_src_sel;

  assign w_nonempty = (w_q_count != '0);
  assign w_mc_ready = !reset_i && (w_q_count < Q_FULL);
  assign w_accept   = mc_valid_i && w_mc_ready;

  // A head squashed on the cycle its age saturated reaches FORCE dead;
  // there is nothing worth stalling for, so it is simply dropped.
  assign w_force = (r_state == ST_FORCE) && w_head_live;

  arb_write_queue #(
    .DEPTH (QUEUE_DEPTH),
    .CW    (CW)
  ) u_queue (
    .i_clk        (clock_i),
    .i_rst        (reset_i),
    .i_push       (w_accept),
    .i_push_sel   (mc_select_i),
    .i_push_val   (mc_value_i),
    .i_pop        (w_pop),
    .i_squash     (w_grant_wb),
    .i_squash_sel (wb_select_i),
    .o_count      (w_q_count),
    .o_head_live  (w_head_live),
    .o_head_sel   (w_head_sel),
    .o_head_val   (w_head_val),
    .o_any_live   (w_any_live)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_age   <= '0;
    end else begin
      r_state <= w_next_state;
      r_age   <= w_next_age;
    end
  end

  always_comb begin
    w_grant_wb   = 1'b0;
    w_grant_q    = 1'b0;
    w_pop        = 1'b0;
    w_stall      = 1'b0;
    w_next_age   = r_age;
    w_next_state = r_state;
    w_next_count = w_q_count + CW'(w_accept) - CW'(w_pop);

    // Port priority: forced head, then pipeline, then live head.
    // A dead head is discarded whenever the port is not forced; it never
    // occupies the port itself.
    if (w_force) begin
      w_grant_q = 1'b1;
      w_pop     = 1'b1;
      w_stall   = 1'b1;
    end else if (wb_enable_i) begin
      w_grant_wb = 1'b1;
      w_pop      = w_nonempty && !w_head_live;
    end else if (w_nonempty) begin
      w_grant_q = w_head_live;
      w_pop     = 1'b1;
    end

    w_next_count = w_q_count + CW'(w_accept) - CW'(w_pop);

    // A live head that is not popped was denied the port this cycle.
    if (w_pop || !w_nonempty) begin
      w_next_age = '0;
    end else if (w_head_live && (r_age != AGE_MAX)) begin
      w_next_age = r_age + AW'(1);
    end

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_DRAIN;
        end
      end
      default: begin
        if (w_next_count == '0) begin
          w_next_state = ST_IDLE;
        end else if (w_next_age == AGE_MAX) begin
          w_next_state = ST_FORCE;
        end else begin
          w_next_state = ST_DRAIN;
        end
      end
    endcase
  end

  assign w_port_en = !reset_i && (w_grant_wb || w_grant_q);

  mux2 #(.W(DATA_W)) u_val_src (
    .i_sel (w_grant_q),
    .i_d0  (wb_value_i),
    .i_d1  (w_head_val),
    .o_y   (w_src_val)
  );

  mux2 #(.W(REG_IDX_W)) u_sel_src (
    .i_sel (w_grant_q),
    .i_d0  (wb_select_i),
    .i_d1  (w_head_sel),
    .o_y   (w_src_sel)
  );

  // Second stage forces data and index to zero when nobody holds the port.
  mux2 #(.W(DATA_W)) u_val_out (
    .i_sel (w_port_en),
    .i_d0  ('0),
    .i_d1  (w_src_val),
    .o_y   (write_reg_o)
  );

  mux2 #(.W(REG_IDX_W)) u_sel_out (
    .i_sel (w_port_en),
    .i_d0  ('0),
    .i_d1  (w_src_sel),
    .o_y   (select_write_reg_o)
  );

  assign reg_write_enable_o = w_port_en;
  assign mc_ready_o         = w_mc_ready;
  assign stall_o            = !reset_i && w_stall;
  assign busy_o             = !reset_i && w_any_live;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_write_arbiter
// Directed, table-driven bench for reg_write_arbiter (STARVE_LIMIT=4,
// QUEUE_DEPTH=2). Each table row is one clock cycle: inputs are driven after
// the falling edge and outputs are compared 4 ns later, well before the next
// rising edge. A hand-written sequence covers an asynchronous reset pulse
// in the middle of a cycle with a full queue.
// -----------------------------------------------------------------------------
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst;
  logic        wbe;
  logic [4:0]  wbs;
  logic [31:0] wbv;
  logic        mcv;
  logic [4:0]  mcs;
  logic [31:0] mcd;
  logic        ready;
  logic        stall;
  logic [31:0] wdata;
  logic [4:0]  wsel;
  logic        we;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        wbe;
    logic [4:0]  wbs;
    logic [31:0] wbv;
    logic        mcv;
    logic [4:0]  mcs;
    logic [31:0] mcd;
    logic        e_ready;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_sel;
    logic [31:0] e_data;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  reg_write_arbiter #(
    .STARVE_LIMIT (4),
    .QUEUE_DEPTH  (2)
  ) dut (
    .clock_i            (clk),
    .reset_i            (rst),
    .wb_enable_i        (wbe),
    .wb_select_i        (wbs),
    .wb_value_i         (wbv),
    .mc_valid_i         (mcv),
    .mc_select_i        (mcs),
    .mc_value_i         (mcd),
    .mc_ready_o         (ready),
    .stall_o            (stall),
    .write_reg_o        (wdata),
    .select_write_reg_o (wsel),
    .reg_write_enable_o (we),
    .busy_o             (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_v(input logic r, input logic e, input logic [4:0] s, input logic [31:0] v,
                       input logic mv, input logic [4:0] ms, input logic [31:0] md,
                       input logic xr, input logic xs, input logic xw, input logic [4:0] xsel,
                       input logic [31:0] xd, input logic xb);
    vec_t t;
    t.rst = r;  t.wbe = e;  t.wbs = s;  t.wbv = v;
    t.mcv = mv; t.mcs = ms; t.mcd = md;
    t.e_ready = xr; t.e_stall = xs; t.e_we = xw;
    t.e_sel = xsel; t.e_data = xd;  t.e_busy = xb;
    vecs.push_back(t);
  endtask

  task automatic add_idle();
    add_v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic drive(input logic e, input logic [4:0] s, input logic [31:0] v,
                       input logic mv, input logic [4:0] ms, input logic [31:0] md);
    wbe = e; wbs = s; wbv = v;
    mcv = mv; mcs = ms; mcd = md;
  endtask

  task automatic check_all(input string tag, input logic xr, input logic xs, input logic xw,
                           input logic [4:0] xsel, input logic [31:0] xd, input logic xb);
    check({tag, " ready"}, 32'(ready), 32'(xr));
    check({tag, " stall"}, 32'(stall), 32'(xs));
    check({tag, " we"},    32'(we),    32'(xw));
    check({tag, " sel"},   32'(wsel),  32'(xsel));
    check({tag, " data"},  wdata,      xd);
    check({tag, " busy"},  32'(busy),  32'(xb));
  endtask

  // ---------------- main test ----------------
  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // Reset held: every output gated to zero even with both requesters active.
    add_v(1, 1, 2, 32'h55, 1, 4, 32'h44,     0, 0, 0, 0, 0, 0);
    add_idle();                                               // first cycle out of reset
    // Idle pipeline, mc push r5 -> written next cycle, then not busy.
    add_v(0, 0, 0, 0, 1, 5, 32'h1234,        1, 0, 0, 0, 0, 0);
    add_v(0, 0, 0, 0, 0, 0, 0,               1, 0, 1, 5, 32'h1234, 1);
    add_idle();
    // Same-cycle accept r3 and pipeline write r3: accepted entry is dead.
    add_v(0, 1, 3, 32'h33, 1, 3, 32'h77,     1, 0, 1, 3, 32'h33, 0);
    add_idle();                                               // dead head dropped silently
    add_idle();
    // Queue r7=AA, pipeline writes r7=BB: only BB reaches the register file.
    add_v(0, 0, 0, 0, 1, 7, 32'hAA,          1, 0, 0, 0, 0, 0);
    add_v(0, 1, 7, 32'hBB, 0, 0, 0,          1, 0, 1, 7, 32'hBB, 1);
    add_idle();
    add_idle();
    // Fill the queue while the pipeline holds the port, then drain.
    add_v(0, 0, 0, 0, 1, 8, 32'h100,         1, 0, 0, 0, 0, 0);
    add_v(0, 1, 1, 32'h11, 1, 9, 32'h200,    1, 0, 1, 1, 32'h11, 1);
    add_v(0, 1, 1, 32'h12, 1, 10, 32'h300,   0, 0, 1, 1, 32'h12, 1);  // full
    add_v(0, 0, 0, 0, 1, 10, 32'h300,        0, 0, 1, 8, 32'h100, 1); // pop, still no accept
    add_v(0, 0, 0, 0, 1, 10, 32'h300,        1, 0, 1, 9, 32'h200, 1); // accept + pop
    add_v(0, 0, 0, 0, 0, 0, 0,               1, 0, 1, 10, 32'h300, 1);
    add_idle();
    // Starvation: pipeline writes r2 every cycle, queued r12 forced on 5th cycle.
    add_v(0, 1, 2, 32'h20, 1, 12, 32'hC0DE,  1, 0, 1, 2, 32'h20, 0);
    for (int k = 1; k <= 4; k++) begin
      add_v(0, 1, 2, 32'h20 + 32'(k), 0, 0, 0, 1, 0, 1, 2, 32'h20 + 32'(k), 1);
    end
    add_v(0, 1, 2, 32'h25, 0, 0, 0,          1, 1, 1, 12, 32'hC0DE, 1);
    add_v(0, 1, 2, 32'h26, 0, 0, 0,          1, 0, 1, 2, 32'h26, 0);
    add_idle();

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      drive(vecs[i].wbe, vecs[i].wbs, vecs[i].wbv, vecs[i].mcv, vecs[i].mcs, vecs[i].mcd);
      #4;
      check_all($sformatf("row%0d", i), vecs[i].e_ready, vecs[i].e_stall, vecs[i].e_we,
                vecs[i].e_sel, vecs[i].e_data, vecs[i].e_busy);
    end

    // Mid-cycle reset with two live entries queued.
    @(negedge clk);
    drive(1, 2, 32'h1, 1, 20, 32'hA20);
    #4;
    check("rs_fill0 ready", 32'(ready), 32'd1);
    @(negedge clk);
    drive(1, 2, 32'h2, 1, 21, 32'hA21);
    #4;
    check("rs_fill1 ready", 32'(ready), 32'd1);
    check("rs_fill1 busy",  32'(busy),  32'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #4;
    check("rs_pre we",  32'(we),   32'd1);
    check("rs_pre sel", 32'(wsel), 32'd20);
    check("rs_pre ready", 32'(ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_all("rs_during", 0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      #4;
      check_all($sformatf("rs_after%0d", c), 1, 0, 0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
